// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - load/store/fetch bridge from core datapath to word-organised memory
//
// Accepts one core request at a time through a valid/ready handshake and classifies it.
// A legal request becomes one word access with lane steering and is held until mem_ack.
// An illegal request is answered directly with resp_err and never reaches memory.
// Load data is shifted down to bit 0 and sign- or zero-extended.
// The answer is a single-cycle resp_valid strobe.
//
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   req_valid/req_ready         core request handshake (ready only in IDLE)
//   req_we/req_funct3           store flag and RV32I width/sign code
//   req_addr/req_wdata          byte address and store data
//   resp_valid/resp_rdata/resp_err   one-cycle response with extended data and fault flag
//   mem_en/mem_we/mem_addr      memory request held until mem_ack, word address
//   mem_be/mem_wdata            byte enables and lane-replicated store data
//   mem_rdata/mem_ack           read word and completion strobe

module lsu_bus_bridge #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                fault;
    logic                timeout_hit;
    logic [3:0]          steer_be;
    logic [31:0]         steer_wdata;
    logic [31:0]         load_shifted;
    logic [31:0]         load_ext;

    // Request classification, evaluated combinationally against the live request in IDLE.
    always_comb begin
        logic bad_funct3;
        logic misaligned;
        logic out_of_window;
        if (req_we) begin
            bad_funct3 = (req_funct3 > 3'b010);
        end else begin
            bad_funct3 = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111);
        end
        // funct3[1:0] is the access size for both signed and unsigned forms.
        misaligned    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_window = ((req_addr >> (ADDR_W + 2)) != 32'd0);
        fault         = bad_funct3 || misaligned || out_of_window;
    end

    // Store lane steering; loads always read the full word.
    always_comb begin
        steer_be    = 4'b1111;
        steer_wdata = 32'd0;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    steer_be    = 4'b0001 << req_addr[1:0];
                    steer_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    steer_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    steer_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    steer_be    = 4'b1111;
                    steer_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the latched byte offset.
    always_comb begin
        load_shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b100:  load_ext = {24'd0, load_shifted[7:0]};
            3'b101:  load_ext = {16'd0, load_shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // The count is the number of ACCESS cycles already spent without an ack.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register and latched request/response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
            addr_q   <= '0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = fault ? RESP : ACCESS;
            ACCESS:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    addr_d   = req_addr[ADDR_W+1:2];
                    be_d     = steer_be;
                    wdata_d  = steer_wdata;
                    rdata_d  = 32'd0;
                    err_d    = fault;
                    cnt_d    = '0;
                end
            end
            ACCESS: begin
                // An ack in the same cycle as the timeout takes priority.
                if (mem_ack) begin
                    rdata_d = we_q ? 32'd0 : load_ext;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state so that reset clears mem_en immediately.
    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_en     = (state_q == ACCESS);
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'd0;
        mem_wdata  = 32'd0;
        resp_valid = (state_q == RESP);
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        if (state_q == ACCESS) begin
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_be    = be_q;
            mem_wdata = wdata_q;
        end
        if (state_q == RESP) begin
            resp_rdata = rdata_q;
            resp_err   = err_q;
        end
    end

endmodule
